sdram_responder: RTL and testbench



---
 rtl/sdram_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_sdram_responder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sdram_responder.sv
// sdram_responder
// Device-side model of an 8-bit SDRAM. It decodes the command pins, holds the
// mode register, tracks the open row of each of four banks, serves reads and
// writes from an internal byte array and latches sticky protocol/timing
// violation flags.
//
// Ports
//   C8M                      clock, everything happens on the rising edge
//   RESET                    synchronous active-high reset
//   nCS nRAS nCAS nRWE       command pins
//   CKE                      clock enable (takes effect one edge later)
//   RBA[1:0]                 bank address
//   RA[12:0]                 row / column / mode address
//   DQMH DQML                byte-lane masks, active-low enables
//   RD_IN[7:0]               write data from the controller
//   RD_OUT[7:0] RD_OE        read data and its drive enable
//   MODE[12:0]               last loaded mode register
//   INITED                   a valid LMR has been seen
//   ERR[4:0]                 sticky violation flags
module sdram_responder #(
   parameter int DEPTH_LOG2 = 12,
   parameter int TRCD       = 1,
   parameter int TRP        = 1,
   parameter int TRFC       = 4
) (
   input  logic        C8M,
   input  logic        RESET,
   input  logic        nCS,
   input  logic        nRAS,
   input  logic        nCAS,
   input  logic        nRWE,
   input  logic        CKE,
   input  logic [1:0]  RBA,
   input  logic [12:0] RA,
   input  logic        DQMH,
   input  logic        DQML,
   input  logic [7:0]  RD_IN,
   output logic [7:0]  RD_OUT,
   output logic        RD_OE,
   output logic [12:0] MODE,
   output logic        INITED,
   output logic [4:0]  ERR
);

   localparam int NB    = 4;
   localparam int CW    = 8;
   localparam int MAXCL = 8;   // CL field is 3 bits

   typedef enum logic [2:0] {
      C_NOP, C_ACT, C_RD, C_WR, C_PRE, C_REF, C_LMR
   } cmd_t;

   typedef enum logic { B_IDLE, B_ACTIVE } bank_st_t;

   // Counters are loaded with (t-1) so that a command k edges later is
   // legal when the value it sees has reached zero, i.e. when k >= t.
   function automatic logic [CW-1:0] ld(input int t);
      ld = (t > 1) ? CW'(t - 1) : '0;
   endfunction

   logic                   cke_r;
   cmd_t                   cmd;
   bank_st_t               bank_st [NB];
   bank_st_t               bank_nx [NB];
   logic [11:0]            bank_row [NB];
   logic [CW-1:0]          trcd_cnt [NB];
   logic [CW-1:0]          trp_cnt;
   logic [CW-1:0]          trfc_cnt;
   logic [4:0]             err_set;
   logic                   any_active;
   logic                   sel_active;
   logic                   mode_ok;
   logic                   lane;
   logic                   mask_all;
   logic [23:0]            full_addr;
   logic [DEPTH_LOG2-1:0]  addr;
   logic [7:0]             mem [2**DEPTH_LOG2];
   logic [MAXCL-1:0]       vld_pipe;
   logic [MAXCL-1:0][7:0]  dat_pipe;
   logic [2:0]             cl;
   logic [2:0]             slot;

   // ---------------- command decode ----------------
   always_comb begin
      cmd = C_NOP;
      if (cke_r && !nCS) begin
         case ({nRAS, nCAS, nRWE})
            3'b011:  cmd = C_ACT;
            3'b101:  cmd = C_RD;
            3'b100:  cmd = C_WR;
            3'b010:  cmd = C_PRE;
            3'b001:  cmd = C_REF;
            3'b000:  cmd = C_LMR;
            default: cmd = C_NOP;   // NOP and burst stop
         endcase
      end
   end

   assign mode_ok    = (RA[2:0] == 3'b000) && (RA[6:4] == 3'd2 || RA[6:4] == 3'd3);
   assign sel_active = (bank_st[RBA] == B_ACTIVE);
   assign lane       = DQML && !DQMH;
   assign mask_all   = DQML && DQMH;
   assign full_addr  = {RBA, bank_row[RBA], RA[8:0], lane};
   assign addr       = DEPTH_LOG2'(full_addr);

   // CL of 0 or 1 both land directly in the output stage.
   assign cl   = MODE[6:4];
   assign slot = (cl == 3'd0) ? 3'd0 : cl - 3'd1;

   // ---------------- bank FSM next state and violation detection ----------------
   always_comb begin
      for (int b = 0; b < NB; b++) bank_nx[b] = bank_st[b];
      err_set    = '0;
      any_active = 1'b0;
      for (int b = 0; b < NB; b++) any_active = any_active | (bank_st[b] == B_ACTIVE);

      case (cmd)
         C_ACT: begin
            if (sel_active)     err_set[0] = 1'b1;
            if (trp_cnt != '0)  err_set[2] = 1'b1;
            if (!INITED)        err_set[4] = 1'b1;
            bank_nx[RBA] = B_ACTIVE;
         end
         C_RD, C_WR: begin
            if (!sel_active || trcd_cnt[RBA] != '0) err_set[1] = 1'b1;
            if (!INITED)                            err_set[4] = 1'b1;
         end
         C_PRE: begin
            if (RA[10]) begin
               for (int b = 0; b < NB; b++) bank_nx[b] = B_IDLE;
            end else begin
               bank_nx[RBA] = B_IDLE;
            end
         end
         C_REF: begin
            if (trp_cnt != '0) err_set[2] = 1'b1;
            if (any_active)    err_set[3] = 1'b1;
         end
         C_LMR: begin
            if (trp_cnt != '0) err_set[2] = 1'b1;
            if (any_active)    err_set[3] = 1'b1;
            if (!mode_ok)      err_set[4] = 1'b1;
         end
         default: ;
      endcase

      if (cmd != C_NOP && trfc_cnt != '0) err_set[2] = 1'b1;
   end

   // ---------------- bank state, counters, mode, flags ----------------
   always_ff @(posedge C8M) begin
      if (RESET) begin
         cke_r    <= 1'b1;
         trp_cnt  <= '0;
         trfc_cnt <= '0;
         MODE     <= '0;
         INITED   <= 1'b0;
         ERR      <= '0;
         for (int b = 0; b < NB; b++) begin
            bank_st[b]  <= B_IDLE;
            bank_row[b] <= '0;
            trcd_cnt[b] <= '0;
         end
      end else begin
         cke_r <= CKE;
         ERR   <= ERR | err_set;

         for (int b = 0; b < NB; b++) begin
            bank_st[b] <= bank_nx[b];
            if (trcd_cnt[b] != '0) trcd_cnt[b] <= trcd_cnt[b] - 1'b1;
         end
         if (trp_cnt  != '0) trp_cnt  <= trp_cnt  - 1'b1;
         if (trfc_cnt != '0) trfc_cnt <= trfc_cnt - 1'b1;

         case (cmd)
            C_ACT: begin
               bank_row[RBA] <= RA[11:0];
               trcd_cnt[RBA] <= ld(TRCD);
            end
            C_PRE: trp_cnt  <= ld(TRP);
            C_REF: trfc_cnt <= ld(TRFC);
            C_LMR: begin
               MODE <= RA;
               if (mode_ok) INITED <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ---------------- byte array (contents survive reset) ----------------
   always_ff @(posedge C8M) begin
      if (!RESET && cmd == C_WR && sel_active && !mask_all)
         mem[addr] <= RD_IN;
   end

   // ---------------- read pipeline ----------------
   // Stage 0 is the output register. A read enters at stage CL-1 and shifts
   // toward stage 0, so it is visible after edge n+CL-1. The pipeline keeps
   // moving while CKE suspends command decode.
   always_ff @(posedge C8M) begin
      if (RESET) begin
         vld_pipe <= '0;
         dat_pipe <= '0;
      end else begin
         for (int i = 0; i < MAXCL - 1; i++) begin
            vld_pipe[i] <= vld_pipe[i+1];
            dat_pipe[i] <= dat_pipe[i+1];
         end
         vld_pipe[MAXCL-1] <= 1'b0;
         dat_pipe[MAXCL-1] <= '0;
         if (cmd == C_RD && sel_active) begin
            vld_pipe[slot] <= !mask_all;
            dat_pipe[slot] <= mask_all ? 8'h00 : mem[addr];
         end
      end
   end

   assign RD_OE  = vld_pipe[0];
   assign RD_OUT = dat_pipe[0];

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: drives command sequences one edge at a
// time and compares outputs sampled 1 ns after each rising edge against
// hand-computed values.
module tb_sdram_responder;

   logic        C8M = 1'b0;
   logic        RESET;
   logic        nCS, nRAS, nCAS, nRWE, CKE;
   logic [1:0]  RBA;
   logic [12:0] RA;
   logic        DQMH, DQML;
   logic [7:0]  RD_IN;
   logic [7:0]  RD_OUT;
   logic        RD_OE;
   logic [12:0] MODE;
   logic        INITED;
   logic [4:0]  ERR;

   int checks = 0;
   int errors = 0;

   sdram_responder dut (
      .C8M(C8M), .RESET(RESET), .nCS(nCS), .nRAS(nRAS), .nCAS(nCAS),
      .nRWE(nRWE), .CKE(CKE), .RBA(RBA), .RA(RA), .DQMH(DQMH), .DQML(DQML),
      .RD_IN(RD_IN), .RD_OUT(RD_OUT), .RD_OE(RD_OE), .MODE(MODE),
      .INITED(INITED), .ERR(ERR)
   );

   always #5 C8M = ~C8M;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Present one command, wait for the edge that samples it, settle 1 ns.
   task automatic cmd(input logic [2:0] rcw, input logic [1:0] ba, input logic [12:0] a,
                      input logic dh, input logic dl, input logic [7:0] d, input logic ce);
      nCS = 1'b0; {nRAS, nCAS, nRWE} = rcw;
      RBA = ba; RA = a; DQMH = dh; DQML = dl; RD_IN = d; CKE = ce;
      @(posedge C8M); #1;
   endtask

   task automatic nop();                          cmd(3'b111, 2'd0, 13'h0, 1'b1, 1'b1, 8'h00, 1'b1); endtask
   task automatic act(input logic [1:0] b, input logic [12:0] row); cmd(3'b011, b, row, 1'b1, 1'b1, 8'h00, 1'b1); endtask
   task automatic lmr(input logic [12:0] a);     cmd(3'b000, 2'd0, a, 1'b1, 1'b1, 8'h00, 1'b1); endtask
   task automatic aref();                         cmd(3'b001, 2'd0, 13'h0, 1'b1, 1'b1, 8'h00, 1'b1); endtask
   task automatic pre_all();                      cmd(3'b010, 2'd0, 13'h400, 1'b1, 1'b1, 8'h00, 1'b1); endtask
   task automatic rd(input logic [1:0] b, input logic [12:0] col, input logic dh, input logic dl);
      cmd(3'b101, b, col, dh, dl, 8'h00, 1'b1);
   endtask
   task automatic wr(input logic [1:0] b, input logic [12:0] col, input logic dh, input logic dl, input logic [7:0] d);
      cmd(3'b100, b, col, dh, dl, d, 1'b1);
   endtask

   task automatic do_reset();
      RESET = 1'b1; nop(); nop(); RESET = 1'b0;
   endtask

   initial begin
      nCS = 1'b1; {nRAS, nCAS, nRWE} = 3'b111; CKE = 1'b1;
      RBA = '0; RA = '0; DQMH = 1'b1; DQML = 1'b1; RD_IN = '0;
      do_reset();

      // reset state
      chk("rst_oe",     RD_OE,  1'b0);
      chk("rst_out",    RD_OUT, 8'h00);
      chk("rst_mode",   MODE,   13'h0);
      chk("rst_inited", INITED, 1'b0);
      chk("rst_err",    ERR,    5'h00);

      // ACT before LMR, then READ to an idle bank
      act(2'd0, 13'd5);
      chk("act_noinit_err", ERR, 5'h10);
      rd(2'd1, 13'd3, 1'b1, 1'b0);
      chk("rd_idle_err", ERR, 5'h12);
      chk("rd_idle_oe0", RD_OE, 1'b0);
      nop();
      chk("rd_idle_oe1", RD_OE, 1'b0);

      // CL2 write/read to lane 0, consecutive edges
      do_reset();
      lmr(13'h220);
      chk("lmr_mode",   MODE,   13'h220);
      chk("lmr_inited", INITED, 1'b1);
      act(2'd0, 13'd5);
      wr(2'd0, 13'd3, 1'b1, 1'b0, 8'hA5);
      rd(2'd0, 13'd3, 1'b1, 1'b0);
      chk("cl2_oe_early", RD_OE, 1'b0);
      nop();
      chk("cl2_oe",  RD_OE,  1'b1);
      chk("cl2_dat", RD_OUT, 8'hA5);
      nop();
      chk("cl2_oe_end", RD_OE, 1'b0);
      chk("cl2_err",    ERR,   5'h00);

      // lane 1 write, then back-to-back reads of both lanes
      wr(2'd0, 13'd3, 1'b0, 1'b1, 8'h3C);
      rd(2'd0, 13'd3, 1'b1, 1'b0);
      rd(2'd0, 13'd3, 1'b0, 1'b1);
      chk("b2b_oe_a",  RD_OE,  1'b1);
      chk("b2b_dat_a", RD_OUT, 8'hA5);
      nop();
      chk("b2b_oe_b",  RD_OE,  1'b1);
      chk("b2b_dat_b", RD_OUT, 8'h3C);
      nop();
      chk("b2b_oe_end", RD_OE, 1'b0);

      // CKE low sampled on the edge before the WRITE suspends it
      cmd(3'b111, 2'd0, 13'h0, 1'b1, 1'b1, 8'h00, 1'b0);
      wr(2'd0, 13'd3, 1'b1, 1'b0, 8'hFF);
      rd(2'd0, 13'd3, 1'b1, 1'b0);
      nop();
      chk("cke_oe",  RD_OE,  1'b1);
      chk("cke_dat", RD_OUT, 8'hA5);

      // fully masked read never drives
      rd(2'd0, 13'd3, 1'b1, 1'b1);
      nop();
      chk("mask_oe", RD_OE, 1'b0);
      chk("mask_err", ERR, 5'h00);

      // AREF with banks open, then ACTs inside tRFC
      act(2'd1, 13'd7);
      aref();
      chk("aref_active_err", ERR, 5'h08);
      act(2'd2, 13'd1);
      chk("trfc_err", ERR, 5'h0C);
      act(2'd0, 13'd9);
      chk("act_active_err", ERR, 5'h0D);
      pre_all();
      rd(2'd1, 13'd0, 1'b1, 1'b0);
      chk("pre_all_rd_err", ERR, 5'h0F);
      nop();
      chk("pre_all_rd_oe", RD_OE, 1'b0);

      // CL3 read latency
      do_reset();
      chk("rst2_err", ERR, 5'h00);
      lmr(13'h230);
      chk("cl3_mode", MODE, 13'h230);
      act(2'd0, 13'd5);
      rd(2'd0, 13'd3, 1'b1, 1'b0);
      chk("cl3_oe_n0", RD_OE, 1'b0);
      nop();
      chk("cl3_oe_n1", RD_OE, 1'b0);
      nop();
      chk("cl3_oe_n2",  RD_OE,  1'b1);
      chk("cl3_dat_n2", RD_OUT, 8'hA5);
      nop();
      chk("cl3_oe_n3", RD_OE, 1'b0);

      // reset one cycle after a CL3 read flushes it
      rd(2'd0, 13'd3, 1'b1, 1'b0);
      RESET = 1'b1;
      nop();
      RESET = 1'b0;
      chk("flush_oe_a", RD_OE, 1'b0);
      nop();
      chk("flush_oe_b", RD_OE, 1'b0);
      nop();
      chk("flush_oe_c", RD_OE, 1'b0);
      chk("flush_err",  ERR,   5'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
